somador_seq: RTL and testbench
==============================

SOMADOR_SEQ -- requirements
Module: somador_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port s, output, WIDTH bits: the sum.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, with the following transitions:
- IDLE->RUN on accepted start.
- RUN->DONE after chunk NCHUNK-1.
- DONE->RUN on accepted start.
- DONE->IDLE otherwise.
REQ-014 start SHALL be accepted only when busy=0 (IDLE or DONE); on the accepting edge k the block SHALL capture a, b and cin into internal registers.
REQ-015 start SHALL be ignored while busy=1; the captured operands are never altered mid-operation.
REQ-016 In RUN, chunk i (bits i*CHUNK..i*CHUNK+CHUNK-1) SHALL be added on edge k+1+i, using the carry registered from chunk i-1 (captured cin for i=0); the sum SHALL be written into s.
REQ-017 busy SHALL be high exactly in the cycles following edges k..k+NCHUNK-1.
REQ-018 done SHALL be high for exactly one cycle, the cycle after edge k+NCHUNK, with busy=0.
REQ-019 At done: s = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum; ovf = (a[MSB]==b'[MSB]) && (s[MSB]!=a[MSB]), where b' is the effective second operand.
REQ-020 s, cout and ovf SHALL hold their values from done until the next accepted start.
REQ-021 Between an accepted start and the following done, s SHALL be updated chunk by chunk; s, cout and ovf are not valid until done.
REQ-022 For CHUNK=WIDTH, latency SHALL be 1 cycle: done is high in the cycle after edge k+1.
REQ-023 start held high continuously SHALL yield back-to-back operations: a new operation is accepted in each DONE cycle.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state IDLE and busy=0, done=0, s=0, cout=0, ovf=0, with all internal operand and carry registers cleared.
REQ-025 A reset during RUN SHALL abort the operation; no done SHALL be produced for it.
REQ-026 The first start after reset release SHALL be accepted normally.

Configuration
REQ-027 Macro SOMADOR_SEQ_SUB_EN defined: the block SHALL add input port sub (1 bit), sampled with start.
- sub=1: b' = ~b and the effective carry-in = 1 (cin ignored), computing a-b; cout=1 means no borrow.
- sub=0: behaviour as without the macro.
REQ-028 Macro SOMADOR_SEQ_SUB_EN undefined: port sub SHALL not exist, and b' = b.

Structure
REQ-029 Package somador_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and a constant function deriving NCHUNK and the chunk-index width.
REQ-030 Each chunk addition SHALL be performed by one instance of sub-module somador_fatia: combinational, parameter CHUNK, with inputs a, b, cin and outputs s, cout.
REQ-031 An elaboration-time check SHALL reject WIDTH not divisible by CHUNK.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-032 a=0x00FF, b=0x0001, cin=0 -> done 4 cycles after start; s=0x0100, cout=0, ovf=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
REQ-034 start pulsed again 2 cycles into an operation (a=0x1234, b=0x1111) -> ignored; single done with s=0x2345; busy high for exactly 4 cycles.
REQ-035 rst_n driven low during chunk 2 -> outputs 0 immediately, no done; a new start (a=1, b=2, cin=1) -> s=0x0004.
REQ-036 With SOMADOR_SEQ_SUB_EN, sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> s=0x7FFF, ovf=1.
REQ-037 WIDTH=8, CHUNK=8, start held high -> done every other cycle (done high in each DONE cycle, busy high in the RUN cycle between); a=0x80, b=0x80 -> s=0x00, cout=1, ovf=1.

Source files
------------

// File: rtl/somador_pkg.sv
// somador_pkg
// Shared definitions for the sequential chunked adder somador_seq:
//   - state_t      : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - nchunk()     : number of chunks an operand is split into
//   - idx_width()  : width of the chunk index register (at least 1 bit)
package somador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/somador_fatia.sv
// somador_fatia
// Combinational CHUNK-bit ripple slice used by somador_seq for one chunk per cycle.
// Ports:
//   a, b  : chunk operands (CHUNK bits)
//   cin   : carry into the chunk
//   s     : chunk sum (CHUNK bits)
//   cout  : carry out of the chunk MSB
module somador_fatia #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // Widen by one bit so the carry out falls into the top bit of the result.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/somador_seq.sv
// somador_seq
// Sequential adder that adds two WIDTH-bit operands CHUNK bits per clock cycle.
// Operands are captured when start is accepted (busy=0); the sum is built chunk
// by chunk and is valid, together with cout and ovf, in the single done cycle.
// Results then hold until the next accepted start.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, ignored while busy
//   a, b   : operands (WIDTH bits)
//   cin    : carry-in
//   sub    : (only with SOMADOR_SEQ_SUB_EN) 1 = compute a-b, sampled with start
//   busy   : addition in progress
//   done   : one-cycle pulse, result valid
//   s      : sum (WIDTH bits)
//   cout   : carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf    : two's-complement signed overflow
// Configuration macro: SOMADOR_SEQ_SUB_EN adds the sub port and subtraction.
module somador_seq
    import somador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SOMADOR_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(WIDTH, CHUNK);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("somador_seq: WIDTH must be an integer multiple of CHUNK");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              start_ok;
    logic              last_chunk;
    int                shamt;
    logic [CHUNK-1:0]  a_chunk, b_chunk, sum_chunk;
    logic              carry_out;

    // Effective second operand and carry-in; subtraction is a + ~b + 1.
    always_comb begin
`ifdef SOMADOR_SEQ_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : cin;
`else
        b_eff   = b;
        cin_eff = cin;
`endif
    end

    // Select the chunk currently being added out of the captured operands.
    always_comb begin
        shamt      = int'(idx_q) * CHUNK;
        a_chunk    = CHUNK'(a_q >> shamt);
        b_chunk    = CHUNK'(b_q >> shamt);
        last_chunk = (idx_q == IDXW'(NCHUNK - 1));
        start_ok   = start && (state_q != ST_RUN);
    end

    somador_fatia #(
        .CHUNK (CHUNK)
    ) u_fatia (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .s    (sum_chunk),
        .cout (carry_out)
    );

    // Next-state logic. The b register holds the effective operand b', so the
    // overflow test at the last chunk compares against its MSB directly.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_d     = (s_q & ~(CHUNK_MASK << shamt)) | (WIDTH'(sum_chunk) << shamt);
                carry_d = carry_out;
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    cout_d  = carry_out;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum_chunk[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_somador_seq.sv
// tb_somador_seq
// Directed-vector bench for somador_seq: a 16-bit/4-bit-chunk instance for the
// main scenarios and an 8-bit/8-bit-chunk instance for single-cycle operation.
// Subtraction vectors are included when SOMADOR_SEQ_SUB_EN is defined.
module tb_somador_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
`ifdef SOMADOR_SEQ_SUB_EN
    logic        sub;
    logic        sub8;
`endif
    logic        busy, done, cout, ovf;
    logic [15:0] s;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        cin8;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  s8;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    somador_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SOMADOR_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    somador_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SOMADOR_SEQ_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    // Pulse start for one cycle; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; cycles = 0 means it never came.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({busy, done, cout, ovf, s} !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b cout=%b ovf=%b s=%h, expected all 0",
                     busy, done, cout, ovf, s);
        end
        vectors++;
        if ({busy8, done8, cout8, ovf8, s8} !== 12'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs8: got busy=%b done=%b s=%h, expected all 0", busy8, done8, s8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        start_op(16'h00FF, 16'h0001, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_busy: got %b expected 1", busy);
        end
        wait_done(cyc);
        vectors++;
        if (cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got %0d expected 4", cyc);
        end
        vectors++;
        if ({busy, cout, ovf, s} !== {1'b0, 1'b0, 1'b0, 16'h0100}) begin
            miscompares++;
            $display("[TB] FAIL basic_result: got busy=%b cout=%b ovf=%b s=%h expected 0 0 0 0100",
                     busy, cout, ovf, s);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, s} !== {1'b0, 1'b0, 16'h0100}) begin
            miscompares++;
            $display("[TB] FAIL basic_hold: got done=%b busy=%b s=%h expected 0 0 0100", done, busy, s);
        end
    endtask

    task automatic test_carry_ovf();
        int cyc;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(cyc);
        vectors++;
        if ({cout, ovf, s} !== {1'b1, 1'b0, 16'h0000} || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL carry_wrap: got cyc=%0d cout=%b ovf=%b s=%h expected 4 1 0 0000", cyc, cout, ovf, s);
        end
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(cyc);
        vectors++;
        if ({cout, ovf, s} !== {1'b0, 1'b1, 16'h8000} || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL signed_ovf: got cyc=%0d cout=%b ovf=%b s=%h expected 4 0 1 8000", cyc, cout, ovf, s);
        end
        start_op(16'hA5A5, 16'h5A5A, 1'b1);
        wait_done(cyc);
        vectors++;
        if ({cout, ovf, s} !== {1'b1, 1'b0, 16'h0000} || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL cin_ripple: got cyc=%0d cout=%b ovf=%b s=%h expected 4 1 0 0000", cyc, cout, ovf, s);
        end
    endtask

    task automatic test_ignore_start();
        int busy_cnt;
        int done_cnt;
        logic [15:0] s_at_done;
        start_op(16'h1234, 16'h1111, 1'b0);
        busy_cnt  = (busy === 1'b1) ? 1 : 0;
        done_cnt  = 0;
        s_at_done = 16'hDEAD;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) begin
                a     = 16'hFFFF;
                b     = 16'hFFFF;
                start = 1'b1;
            end else if (j == 2) begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                s_at_done = s;
            end
        end
        vectors++;
        if (busy_cnt != 4) begin
            miscompares++;
            $display("[TB] FAIL ignore_busy_cycles: got %0d expected 4", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1 || s_at_done !== 16'h2345) begin
            miscompares++;
            $display("[TB] FAIL ignore_result: got dones=%0d s=%h expected 1 2345", done_cnt, s_at_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(16'h0001, 16'h0002, 1'b0);
        wait_done(cyc);
        a     = 16'h1000;
        b     = 16'h2000;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b10 || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept: got cyc=%0d busy=%b done=%b expected 4 1 0", cyc, busy, done);
        end
        wait_done(cyc);
        vectors++;
        if (s !== 16'h3000 || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL b2b_result: got cyc=%0d s=%h expected 4 3000", cyc, s);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int saw_done;
        start_op(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, cout, ovf, s} !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got busy=%b done=%b cout=%b ovf=%b s=%h expected all 0",
                     busy, done, cout, ovf, s);
        end
        saw_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) saw_done++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done++;
        end
        vectors++;
        if (saw_done != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", saw_done);
        end
        start_op(16'h0001, 16'h0002, 1'b1);
        wait_done(cyc);
        vectors++;
        if ({cout, ovf, s} !== {1'b0, 1'b0, 16'h0004} || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL post_reset_op: got cyc=%0d cout=%b ovf=%b s=%h expected 4 0 0 0004", cyc, cout, ovf, s);
        end
    endtask

    task automatic test_single_chunk();
        int bad;
        @(negedge clk);
        a8     = 8'h80;
        b8     = 8'h80;
        cin8   = 1'b0;
        start8 = 1'b1;
        bad    = 0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if ((j % 2) == 1) begin
                if ({busy8, done8} !== 2'b10) bad++;
            end else begin
                if ({busy8, done8, cout8, ovf8, s8} !== {4'b0111, 8'h00}) bad++;
            end
        end
        start8 = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL chunk8_stream: got %0d bad cycles expected 0 (last busy=%b done=%b s=%h cout=%b ovf=%b)",
                     bad, busy8, done8, s8, cout8, ovf8);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({busy8, done8, s8} !== {2'b00, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL chunk8_idle: got busy=%b done=%b s=%h expected 0 0 00", busy8, done8, s8);
        end
    endtask

`ifdef SOMADOR_SEQ_SUB_EN
    task automatic test_sub();
        int cyc;
        sub = 1'b1;
        start_op(16'h0005, 16'h0007, 1'b0);
        sub = 1'b0;
        wait_done(cyc);
        vectors++;
        if ({cout, ovf, s} !== {1'b0, 1'b0, 16'hFFFE} || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL sub_borrow: got cyc=%0d cout=%b ovf=%b s=%h expected 4 0 0 FFFE", cyc, cout, ovf, s);
        end
        sub = 1'b1;
        start_op(16'h8000, 16'h0001, 1'b0);
        sub = 1'b0;
        wait_done(cyc);
        vectors++;
        if ({cout, ovf, s} !== {1'b1, 1'b1, 16'h7FFF} || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL sub_ovf: got cyc=%0d cout=%b ovf=%b s=%h expected 4 1 1 7FFF", cyc, cout, ovf, s);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
`ifdef SOMADOR_SEQ_SUB_EN
        sub    = 1'b0;
        sub8   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_carry_ovf();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_single_chunk();
`ifdef SOMADOR_SEQ_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
